// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL lock sequencer.
// Optional lock-loss counter width is used only when PLL_LOCK_LOSS_COUNT_EN is defined.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_seq_state_t;

    localparam int RETRY_CNT_W     = 4;
    localparam int LOCK_LOSS_CNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on rst.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, qualifies lock, releases sys_rst, retries on loss.
// Define PLL_LOCK_LOSS_COUNT_EN to add lock_loss_cnt and lock_lost_pulse.
//
// state        | meaning
// ST_PLL_RST   | pll_rst pulse in progress, sys_rst held
// ST_WAIT_LOCK | pll_rst released, waiting for synchronized lock (timeout window)
// ST_STABLE    | lock seen, counting consecutive locked cycles
// ST_RUN       | sys_rst released, ready high
// ST_FAULT     | retries exhausted; terminal until rst
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int MAX_RETRIES         = 7
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked,
    output logic                   pll_rst,
    output logic                   sys_rst,
    output logic                   ready,
    output logic                   fault,
    output logic [RETRY_CNT_W-1:0] retry_cnt
`ifdef PLL_LOCK_LOSS_COUNT_EN
    ,
    output logic [LOCK_LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic                       lock_lost_pulse
`endif
);

    localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_CNT_W-1:0] RETRY_LIMIT = RETRY_CNT_W'(MAX_RETRIES);

    pll_seq_state_t        state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [RETRY_CNT_W-1:0] retries_used;
    logic                  lock_s;
    logic                  retry_take;
    logic                  lock_lost;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    always_comb begin
        state_nxt  = state;
        retry_take = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (cnt >= PLL_RST_LAST) state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // lock wins over a timeout landing on the same cycle
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                end else if (cnt >= TIMEOUT_LAST) begin
                    if (retries_used < RETRY_LIMIT) begin
                        state_nxt  = ST_PLL_RST;
                        retry_take = 1'b1;
                    end else begin
                        state_nxt = ST_FAULT;
                    end
                end
            end
            ST_STABLE: begin
                if (!lock_s) state_nxt = ST_WAIT_LOCK;
                else if (cnt >= STABLE_LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt  = ST_PLL_RST;
                    retry_take = 1'b1;
                end
            end
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_PLL_RST;
        endcase
    end

    assign lock_lost = (state == ST_RUN) && (state_nxt == ST_PLL_RST);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state        <= ST_PLL_RST;
            cnt          <= '0;
            retries_used <= '0;
            retry_cnt    <= '0;
            pll_rst      <= 1'b1;
            sys_rst      <= 1'b1;
            ready        <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) cnt <= '0;
            else if (cnt != '1)     cnt <= cnt + 1'b1;

            if (retry_take && retry_cnt != '1) retry_cnt <= retry_cnt + 1'b1;

            // budget refills on every successful bring-up; retry_cnt keeps history
            if (state_nxt == ST_RUN && state != ST_RUN)   retries_used <= '0;
            else if (retry_take && retries_used != '1)     retries_used <= retries_used + 1'b1;

            // outputs follow the next state so they change on the entry edge
            pll_rst <= (state_nxt == ST_PLL_RST) || (state_nxt == ST_FAULT);
            sys_rst <= (state_nxt != ST_RUN);
            ready   <= (state_nxt == ST_RUN);
            fault   <= fault | (state_nxt == ST_FAULT);
        end
    end

`ifdef PLL_LOCK_LOSS_COUNT_EN
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_loss_cnt   <= '0;
            lock_lost_pulse <= 1'b0;
        end else begin
            lock_lost_pulse <= lock_lost;
            if (lock_lost && lock_loss_cnt != '1) lock_loss_cnt <= lock_loss_cnt + 1'b1;
        end
    end
`else
    logic unused_lock_lost;
    assign unused_lock_lost = lock_lost;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer; edges counted from the rst release edge.
module tb_pll_lock_sequencer;

    localparam int P    = 16;
    localparam int T    = 200;
    localparam int S    = 1024;
    localparam int M    = 3;
    localparam int SYNC = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_rst, ready, fault;
    logic [3:0] retry_cnt;
`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [7:0] lock_loss_cnt;
    logic       lock_lost_pulse;
`endif

    int vectors = 0;
    int miscompares = 0;
    int now = 0;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES      (P),
        .LOCK_TIMEOUT_CYCLES (T),
        .STABLE_CYCLES       (S),
        .MAX_RETRIES         (M)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt)
`ifdef PLL_LOCK_LOSS_COUNT_EN
        ,
        .lock_loss_cnt   (lock_loss_cnt),
        .lock_lost_pulse (lock_lost_pulse)
`endif
    );

    always #10 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: lock first sampled at edge r is visible to the sequencer at r+SYNC;
    // it cannot be acted on before the first WAIT_LOCK cycle (edge P+1); release follows S locked cycles.
    function automatic int exp_run_edge(input int r);
        int seen;
        seen = r + SYNC;
        if (seen < P + 1) seen = P + 1;
        return seen + S;
    endfunction

    task automatic tick();
        @(posedge refclk);
        #1;
        now++;
    endtask

    task automatic apply_reset();
        #3 rst = 1'b1;
        #1;
    endtask

    task automatic release_rst();
        @(posedge refclk);
        #1;
        rst = 1'b0;
        now = 0;
    endtask

    task automatic set_lock_at(input int a);
        while (now < a) tick();
        pll_locked = 1'b1;
    endtask

    task automatic wait_fall(input int limit, output int at);
        while (sys_rst === 1'b1 && now < limit) tick();
        at = now;
    endtask

    task automatic high_width(output int w);
        w = 0;
        while (pll_rst === 1'b1 && w < 2000) begin
            tick();
            w++;
        end
    endtask

    task automatic low_width(output int w);
        w = 0;
        while (pll_rst === 1'b0 && w < 2000) begin
            tick();
            w++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, at, a, b, len, r2, st_entry;

        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (3) @(posedge refclk);
        #1;
        check("reset_pll_rst", pll_rst, 1);
        check("reset_sys_rst", sys_rst, 1);
        check("reset_ready", ready, 0);
        check("reset_fault", fault, 0);
        check("reset_retry_cnt", retry_cnt, 0);

        // normal bring-up, lock 100 cycles after release
        release_rst();
        high_width(w);
        check("bringup_pll_rst_width", w, P);
        set_lock_at(100);
        wait_fall(5000, at);
        check("bringup_release_edge", at, exp_run_edge(101));
        check("bringup_ready", ready, 1);
        check("bringup_retry_cnt", retry_cnt, 0);
        check("bringup_pll_rst_low", pll_rst, 0);

        // randomized lock arrival times inside the first window
        for (int k = 0; k < 3; k++) begin
            pll_locked = 1'b0;
            apply_reset();
            release_rst();
            a = $urandom_range(0, 213);
            set_lock_at(a);
            wait_fall(5000, at);
            check("rand_bringup_release_edge", at, exp_run_edge(a + 1));
            check("rand_bringup_retry_cnt", retry_cnt, 0);
        end

        // lock bounces while in STABLE
        pll_locked = 1'b0;
        apply_reset();
        release_rst();
        a = $urandom_range(20, 120);
        set_lock_at(a);
        st_entry = exp_run_edge(a + 1) - S;
        b = st_entry + 500;
        r2 = a + 1;
        for (int i = 0; i < 2; i++) begin
            len = (i == 0) ? 5 : $urandom_range(1, 8);
            while (now < b) tick();
            check("bounce_sys_rst_held", sys_rst, 1);
            pll_locked = 1'b0;
            while (now < b + len) tick();
            check("bounce_sys_rst_during_drop", sys_rst, 1);
            pll_locked = 1'b1;
            r2 = b + len + 1;
            b = r2 + SYNC + $urandom_range(100, 900);
        end
        wait_fall(10000, at);
        check("bounce_release_edge", at, exp_run_edge(r2));
        check("bounce_retry_cnt", retry_cnt, 0);

        // lock loss in RUN
        pll_locked = 1'b0;
        tick();
        tick();
        check("loss_sys_rst_still_low", sys_rst, 0);
        tick();
        check("loss_sys_rst", sys_rst, 1);
        check("loss_ready", ready, 0);
        check("loss_pll_rst", pll_rst, 1);
        check("loss_retry_cnt", retry_cnt, 1);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        check("loss_pulse_high", lock_lost_pulse, 1);
        check("loss_count", lock_loss_cnt, 1);
`endif
        tick();
`ifdef PLL_LOCK_LOSS_COUNT_EN
        check("loss_pulse_single", lock_lost_pulse, 0);
`endif
        high_width(w);
        check("loss_pll_rst_width", w + 1, P);

        // relock, then async reset in the middle of STABLE
        pll_locked = 1'b1;
        repeat (300) tick();
        check("midstable_sys_rst", sys_rst, 1);
        apply_reset();
        check("async_pll_rst", pll_rst, 1);
        check("async_sys_rst", sys_rst, 1);
        check("async_fault", fault, 0);
        check("async_retry_cnt", retry_cnt, 0);
        check("async_ready", ready, 0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        check("async_loss_count", lock_loss_cnt, 0);
`endif
        release_rst();
        high_width(w);
        check("resume_pll_rst_width", w, P);
        wait_fall(5000, at);
        check("resume_release_edge", at, exp_run_edge(1));

        // lock becomes visible on the last cycle of the timeout window
        pll_locked = 1'b0;
        apply_reset();
        release_rst();
        high_width(w);
        set_lock_at(P + T - SYNC - 1);
        while (now < P + T + 1) tick();
        check("coincide_pll_rst", pll_rst, 0);
        check("coincide_retry_cnt", retry_cnt, 0);
        wait_fall(5000, at);
        check("coincide_release_edge", at, exp_run_edge(P + T - SYNC));

        // lock never arrives: retries then fault
        pll_locked = 1'b0;
        apply_reset();
        release_rst();
        for (int k = 0; k <= M; k++) begin
            high_width(w);
            check("timeout_pulse_width", w, P);
            check("timeout_retry_cnt", retry_cnt, k);
            low_width(w);
            check("timeout_window", w, T);
            check("timeout_fault_flag", fault, (k == M));
        end
        check("fault_edge", now, (M + 1) * (P + T));
        check("fault_pll_rst", pll_rst, 1);
        check("fault_retry_cnt", retry_cnt, M);
        repeat (50) tick();
        check("fault_sticky", fault, 1);
        check("fault_pll_rst_held", pll_rst, 1);
        check("fault_sys_rst", sys_rst, 1);
        check("fault_ready", ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
